mm2s: RTL and testbench

//  Memory-mapped-to-stream DMA reader, the read-side counterpart of the stream-to-memory writer.
//  PS programs a source address and word count, then starts the transfer.
//  The block issues single-beat AXI-lite reads and emits each word on an AXI-stream master, with tlast on the final word.

---
 rtl/mm2s.sv | 255 +++++++++++++++++++++++++
 tb/tb_mm2s.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm2s.sv
// ============================================================================
//  Module   : mm2s
//  Purpose  : Memory-mapped-to-stream DMA reader. Software programs a source
//             address and a word count through the PS register port and
//             writes CTRL.start. The block then issues one single-beat
//             AXI-lite read at a time and forwards each returned word on an
//             AXI-stream master. tlast is asserted on the final word.
//  Options  : MM2S_IRQ_EN adds a level interrupt output, irq = done | error.
//             The interrupt stays high until a CTRL bit1 (clear) write.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mm2s #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,  // must not exceed the 32-bit PS data bus
  parameter int LEN_WIDTH     = 16,  // must not exceed the 32-bit PS data bus
  parameter int PS_ADDR_WIDTH = 4    // PS register address, in word-index units
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // PS register port
  input  logic [PS_ADDR_WIDTH-1:0] ps_waddr,
  input  logic [31:0]             ps_wdata,
  input  logic                    ps_wvalid,
  output logic                    ps_wready,
  output logic                    ps_wresp,
  input  logic [PS_ADDR_WIDTH-1:0] ps_raddr,
  input  logic                    ps_arvalid,
  output logic [31:0]             ps_rdata,
  output logic                    ps_rvalid,
  // AXI-lite master, read channel
  output logic [ADDR_WIDTH-1:0]   mem_araddr,
  output logic                    mem_arvalid,
  input  logic                    mem_arready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic [1:0]              mem_rresp,
  input  logic                    mem_rvalid,
  output logic                    mem_rready,
  // AXI-lite master, write channel (never used by a reader)
  output logic [ADDR_WIDTH-1:0]   mem_awaddr,
  output logic                    mem_awvalid,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic                    mem_wvalid,
  output logic                    mem_bready,
  // AXI-stream master
  output logic [DATA_WIDTH-1:0]   dout_data,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last
`ifdef MM2S_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam logic [PS_ADDR_WIDTH-1:0] c_reg_src    = PS_ADDR_WIDTH'(0);
  localparam logic [PS_ADDR_WIDTH-1:0] c_reg_len    = PS_ADDR_WIDTH'(1);
  localparam logic [PS_ADDR_WIDTH-1:0] c_reg_ctrl   = PS_ADDR_WIDTH'(2);
  localparam logic [PS_ADDR_WIDTH-1:0] c_reg_status = PS_ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0]    c_addr_step  = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [LEN_WIDTH-1:0]     c_len_one    = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_TX   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [ADDR_WIDTH-1:0]   r_src;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LEN_WIDTH-1:0]    r_rem;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_done;
  logic                    r_error;
  logic                    r_wresp;

  logic                    w_busy;
  logic                    w_len_zero;
  logic                    w_start;
  logic                    w_clear;
  logic                    w_wr_src;
  logic                    w_wr_len;
  logic                    w_start_ok;
  logic                    w_r_fire;
  logic                    w_tx_fire;

  // Busy covers the whole transfer; DONE already reports not-busy.
  assign w_busy     = (r_state == ST_AR) || (r_state == ST_R) || (r_state == ST_TX);
  assign w_len_zero = (r_len == '0);

  // Register-write decode. SRC/LENGTH are frozen while a transfer runs.
  assign w_wr_src   = ps_wvalid && (ps_waddr == c_reg_src) && !w_busy;
  assign w_wr_len   = ps_wvalid && (ps_waddr == c_reg_len) && !w_busy;
  assign w_start    = ps_wvalid && (ps_waddr == c_reg_ctrl) && ps_wdata[0];
  assign w_clear    = ps_wvalid && (ps_waddr == c_reg_ctrl) && ps_wdata[1];

  // A start is only honoured from IDLE; starts at any other time are dropped.
  assign w_start_ok = (r_state == ST_IDLE) && w_start;
  assign w_r_fire   = (r_state == ST_R) && mem_rvalid;
  assign w_tx_fire  = (r_state == ST_TX) && dout_ready;

  // PS port: writes are always accepted, reads are answered in the same cycle.
  assign ps_wready  = 1'b1;
  assign ps_wresp   = r_wresp;
  assign ps_rvalid  = ps_arvalid;

  // Combinational register readback.
  always_comb begin
    ps_rdata = 32'd0;
    case (ps_raddr)
      c_reg_src:    ps_rdata = 32'(r_src);
      c_reg_len:    ps_rdata = 32'(r_len);
      c_reg_status: ps_rdata = {29'd0, r_error, r_done, w_busy};
      default:      ps_rdata = 32'd0;
    endcase
  end

  // Write channel is permanently idle.
  assign mem_awaddr  = '0;
  assign mem_awvalid = 1'b0;
  assign mem_wdata   = '0;
  assign mem_wstrb   = '0;
  assign mem_wvalid  = 1'b0;
  assign mem_bready  = 1'b0;

  // Address and data come straight from holding registers, so they stay
  // stable for as long as the matching valid waits for acceptance.
  assign mem_araddr = r_addr;
  assign dout_data  = r_data;

`ifdef MM2S_IRQ_EN
  assign irq = r_done | r_error;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and handshake outputs, decoded from the registered state
  // so that an asynchronous reset drops every valid/ready at once.
  always_comb begin
    w_state_next = r_state;
    mem_arvalid  = 1'b0;
    mem_rready   = 1'b0;
    dout_valid   = 1'b0;
    dout_last    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok && !w_len_zero) begin
          w_state_next = ST_AR;
        end
      end
      ST_AR: begin
        mem_arvalid = 1'b1;
        if (mem_arready) begin
          w_state_next = ST_R;
        end
      end
      ST_R: begin
        mem_rready = 1'b1;
        if (mem_rvalid) begin
          w_state_next = ST_TX;
        end
      end
      ST_TX: begin
        dout_valid = 1'b1;
        dout_last  = (r_rem == c_len_one);
        if (dout_ready) begin
          w_state_next = (r_rem > c_len_one) ? ST_AR : ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Programming registers, transfer counters, data holding register and
  // status flags. Clear is applied before start so "clear+start" in one
  // write behaves as clear followed by start; a read error seen in the same
  // cycle as a clear still sets the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src   <= '0;
      r_len   <= '0;
      r_addr  <= '0;
      r_rem   <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_wresp <= 1'b0;
    end else begin
      r_wresp <= ps_wvalid;

      if (w_wr_src) begin
        r_src <= ps_wdata[ADDR_WIDTH-1:0];
      end
      if (w_wr_len) begin
        r_len <= ps_wdata[LEN_WIDTH-1:0];
      end

      if (w_clear) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end

      if (w_start_ok) begin
        if (w_len_zero) begin
          // Empty transfer: flag it as complete-with-error, no bus traffic.
          r_done  <= 1'b1;
          r_error <= 1'b1;
        end else begin
          r_addr  <= r_src;
          r_rem   <= r_len;
          r_done  <= 1'b0;
          r_error <= 1'b0;
        end
      end

      if (w_r_fire) begin
        r_data <= mem_rdata;
        if (mem_rresp != 2'b00) begin
          r_error <= 1'b1;
        end
      end

      if (w_tx_fire) begin
        r_rem  <= r_rem - c_len_one;
        r_addr <= r_addr + c_addr_step;
        if (r_rem == c_len_one) begin
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mm2s.sv
// ============================================================================
//  Module   : tb_mm2s
//  Purpose  : Self-checking bench for mm2s. A behavioural AXI-lite memory
//             answers reads; expected addresses and stream beats are queued
//             when a transfer is programmed and popped as the DUT emits them.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mm2s;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LW  = 16;
  localparam int PAW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;

  logic [PAW-1:0]  ps_waddr;
  logic [31:0]     ps_wdata;
  logic            ps_wvalid;
  logic            ps_wready;
  logic            ps_wresp;
  logic [PAW-1:0]  ps_raddr;
  logic            ps_arvalid;
  logic [31:0]     ps_rdata;
  logic            ps_rvalid;

  logic [AW-1:0]   mem_araddr;
  logic            mem_arvalid;
  logic            mem_arready;
  logic [DW-1:0]   mem_rdata;
  logic [1:0]      mem_rresp;
  logic            mem_rvalid;
  logic            mem_rready;
  logic [AW-1:0]   mem_awaddr;
  logic            mem_awvalid;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wstrb;
  logic            mem_wvalid;
  logic            mem_bready;

  logic [DW-1:0]   dout_data;
  logic            dout_valid;
  logic            dout_ready;
  logic            dout_last;
`ifdef MM2S_IRQ_EN
  logic            irq;
`endif

  always #5 clk = ~clk;

  mm2s #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .LEN_WIDTH     (LW),
    .PS_ADDR_WIDTH (PAW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps_waddr    (ps_waddr),
    .ps_wdata    (ps_wdata),
    .ps_wvalid   (ps_wvalid),
    .ps_wready   (ps_wready),
    .ps_wresp    (ps_wresp),
    .ps_raddr    (ps_raddr),
    .ps_arvalid  (ps_arvalid),
    .ps_rdata    (ps_rdata),
    .ps_rvalid   (ps_rvalid),
    .mem_araddr  (mem_araddr),
    .mem_arvalid (mem_arvalid),
    .mem_arready (mem_arready),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .mem_rvalid  (mem_rvalid),
    .mem_rready  (mem_rready),
    .mem_awaddr  (mem_awaddr),
    .mem_awvalid (mem_awvalid),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_wvalid  (mem_wvalid),
    .mem_bready  (mem_bready),
    .dout_data   (dout_data),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_last   (dout_last)
`ifdef MM2S_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] src;
    logic [15:0] len;
    int          ready_mode;  // 0: always ready, 1: 1-0-0-1 pattern, 2: never
    int          err_idx;     // word index returning SLVERR, -1 for none
    logic [31:0] status;      // expected STATUS once idle
  } vec_t;

  beat_t       exp_q[$];
  logic [31:0] exp_addr_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          beats = 0;
  int          ar_count = 0;
  int          cyc = 0;
  int          ready_mode = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'd0;

  vec_t        vecs[5];

  // Memory contents as a pure function of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} + 32'h0101_0101;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got 0x%08h required nothing", name, act);
  endtask

  task automatic ps_write(input logic [PAW-1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    ps_waddr  = a;
    ps_wdata  = d;
    ps_wvalid = 1'b1;
    @(posedge clk);
    #1;
    ps_wvalid = 1'b0;
    check("wresp_delayed", {31'd0, ps_wresp}, 32'd1);
  endtask

  task automatic ps_read(input logic [PAW-1:0] a, output logic [31:0] d);
    ps_raddr   = a;
    ps_arvalid = 1'b1;
    #1;
    check("ps_rvalid", {31'd0, ps_rvalid}, 32'd1);
    d          = ps_rdata;
    ps_arvalid = 1'b0;
  endtask

  // Bus monitor + memory responder + ready generator. Handshakes are sampled
  // on the falling edge; responses are driven just after the rising edge.
  initial begin
    logic        p_valid, p_ready, p_last, p_arvalid, p_arready;
    logic [31:0] p_data, p_araddr, hold_addr;
    logic        ar_fire, r_fire, s_fire, pat;
    beat_t       b;
    p_valid = 1'b0; p_ready = 1'b0; p_last = 1'b0;
    p_arvalid = 1'b0; p_arready = 1'b0; p_data = '0; p_araddr = '0;
    hold_addr = '0;
    forever begin
      @(negedge clk);
      ar_fire = 1'b0;
      r_fire  = 1'b0;
      if (rst_n) begin
        if (p_valid && !p_ready) begin
          check("valid_held", {31'd0, dout_valid}, 32'd1);
          check("data_held", dout_data, p_data);
          check("last_held", {31'd0, dout_last}, {31'd0, p_last});
        end
        if (p_arvalid && !p_arready) begin
          check("arvalid_held", {31'd0, mem_arvalid}, 32'd1);
          check("araddr_held", mem_araddr, p_araddr);
        end
        ar_fire = mem_arvalid && mem_arready;
        r_fire  = mem_rvalid && mem_rready;
        s_fire  = dout_valid && dout_ready;
        if (ar_fire) begin
          ar_count++;
          hold_addr = mem_araddr;
          if (exp_addr_q.size() == 0) fail_now("araddr_unexpected", mem_araddr);
          else check("araddr", mem_araddr, exp_addr_q.pop_front());
        end
        if (s_fire) begin
          beats++;
          if (exp_q.size() == 0) fail_now("beat_unexpected", dout_data);
          else begin
            b = exp_q.pop_front();
            check("beat_data", dout_data, b.data);
            check("beat_last", {31'd0, dout_last}, {31'd0, b.last});
          end
        end
        p_valid = dout_valid; p_ready = dout_ready; p_data = dout_data; p_last = dout_last;
        p_arvalid = mem_arvalid; p_arready = mem_arready; p_araddr = mem_araddr;
      end else begin
        p_valid = 1'b0;
        p_arvalid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (r_fire) mem_rvalid = 1'b0;
        if (ar_fire) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(hold_addr);
          mem_rresp  = (err_en && hold_addr == err_addr) ? 2'b10 : 2'b00;
        end
      end else begin
        mem_rvalid = 1'b0;
      end
      cyc++;
      pat = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      dout_ready  = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? pat : 1'b0;
      mem_arready = (ready_mode == 1) ? pat : 1'b1;
    end
  end

  task automatic wait_idle(output logic [31:0] s);
    bit ok;
    ok = 1'b0;
    s  = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ps_read(4'd3, s);
      if (s[0] == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("idle_timeout", s);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] s, a;
    ready_mode = v.ready_mode;
    err_en     = (v.err_idx >= 0);
    err_addr   = v.src + 32'(4 * v.err_idx);
    ps_write(4'd0, v.src);
    ps_write(4'd1, 32'(v.len));
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.src + 32'(4 * i);
      exp_addr_q.push_back(a);
      exp_q.push_back('{data: mem_word(a), last: (i == int'(v.len) - 1)});
    end
    beats = 0;
    ps_write(4'd2, 32'h1);
    check("first_ar_next_cycle", {31'd0, mem_arvalid}, 32'd1);
    wait_idle(s);
    check("beat_count", 32'(beats), 32'(v.len));
    check("exp_beats_left", 32'(exp_q.size()), 32'd0);
    check("status_end", s, v.status);
`ifdef MM2S_IRQ_EN
    check("irq_level", {31'd0, irq}, {31'd0, v.status[1] | v.status[2]});
`endif
    if (v.status[2]) begin
      ps_write(4'd2, 32'h2);
      ps_read(4'd3, s);
      check("status_after_clear", s, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] s;
    int          ar_before;
    bit          seen;
    ps_waddr = '0; ps_wdata = '0; ps_wvalid = 1'b0;
    ps_raddr = '0; ps_arvalid = 1'b0;
    mem_arready = 1'b1; mem_rdata = '0; mem_rresp = 2'b00; mem_rvalid = 1'b0;
    dout_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arvalid", {31'd0, mem_arvalid}, 32'd0);
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    ps_read(4'd3, s); check("rst_status", s, 32'd0);
    ps_read(4'd0, s); check("rst_src", s, 32'd0);
    ps_read(4'd1, s); check("rst_len", s, 32'd0);
    check("rst_rready", {31'd0, mem_rready}, 32'd0);
    check("rst_last", {31'd0, dout_last}, 32'd0);
    ps_read(4'd7, s); check("unmapped_read", s, 32'd0);

    vecs[0] = '{src: 32'h0000_0100, len: 16'd4, ready_mode: 0, err_idx: -1, status: 32'h2};
    vecs[1] = '{src: 32'h0000_0200, len: 16'd3, ready_mode: 1, err_idx: -1, status: 32'h2};
    vecs[2] = '{src: 32'h0000_0300, len: 16'd2, ready_mode: 0, err_idx: 0,  status: 32'h6};
    vecs[3] = '{src: 32'hFFFF_FFFC, len: 16'd2, ready_mode: 0, err_idx: -1, status: 32'h2};
    vecs[4] = '{src: 32'h0000_0040, len: 16'd5, ready_mode: 1, err_idx: 3,  status: 32'h6};
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Zero-length start: done+error immediately, no read issued.
    ready_mode = 0;
    ps_write(4'd1, 32'd0);
    ar_before = ar_count;
    ps_write(4'd2, 32'h1);
    check("len0_no_arvalid", {31'd0, mem_arvalid}, 32'd0);
    ps_read(4'd3, s); check("len0_status", s, 32'h6);
    repeat (5) @(negedge clk);
    check("len0_no_reads", 32'(ar_count), 32'(ar_before));
    ps_write(4'd2, 32'h2);

    // Stall a transfer in TX, poke registers, then reset mid-flight.
    ready_mode = 2;
    err_en     = 1'b0;
    ps_write(4'd0, 32'h0000_0500);
    ps_write(4'd1, 32'd3);
    exp_addr_q.push_back(32'h0000_0500);
    exp_q.push_back('{data: mem_word(32'h0000_0500), last: 1'b0});
    ps_write(4'd2, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dout_valid) begin seen = 1'b1; break; end
    end
    if (!seen) fail_now("tx_timeout", 32'd0);
    ps_write(4'd0, 32'h0000_0777);
    @(negedge clk);
    ps_read(4'd0, s); check("src_frozen_busy", s, 32'h0000_0500);
    ps_write(4'd2, 32'h2);
    @(negedge clk);
    ps_read(4'd3, s); check("clear_keeps_busy", s, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, dout_valid}, 32'd0);
    check("arst_arvalid", {31'd0, mem_arvalid}, 32'd0);
    check("arst_rready", {31'd0, mem_rready}, 32'd0);
    mem_rvalid = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ps_read(4'd3, s); check("post_rst_status", s, 32'd0);
    ps_read(4'd0, s); check("post_rst_src", s, 32'd0);

    run_vec('{src: 32'h0000_0600, len: 16'd3, ready_mode: 0, err_idx: -1, status: 32'h2});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
